calc2_core: RTL and testbench
=============================

CALC2_CORE -- requirements
Module: calc2_core

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NCH, 4, number of request channels (1..8).
- DW, 32, operand/result width (8..64, power of two).
REQ-002 Ports, one per line: name, direction, width, meaning.
- c_clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_cmd_in  in  NCH*4  per-channel command; channel k at bits [4k+3:4k].
- req_data_in  in  NCH*DW  per-channel operand bus.
- out_busy  out  NCH  channel holds an unfinished request.
- out_resp  out  NCH*2  per-channel response code.
- out_data  out  NCH*DW  per-channel result.
REQ-003 Command codes: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; every other nonzero code is invalid.
REQ-004 Response codes: 0 none, 1 success, 2 overflow/underflow/invalid, 3 reserved and never driven.

Function
REQ-005 Each channel runs an FSM with states IDLE -> OP2 -> WAIT -> IDLE.
REQ-006 IDLE: a nonzero cmd at an edge captures cmd and operand1 (req_data_in) and moves to OP2.
REQ-007 OP2: the next edge captures operand2 unconditionally and moves to WAIT; req_cmd_in is ignored in OP2 and WAIT.
REQ-008 out_busy[k] SHALL be 1 exactly while channel k is in OP2 or WAIT.
REQ-009 Execution units: one arithmetic unit (ADD/SUB) and one shift unit (LSH/RSH); each completes at most one channel per cycle.
REQ-010 Arbitration per unit is round-robin.
- Grant the lowest channel index >= that unit's pointer among the WAIT channels needing the unit, wrapping modulo NCH.
- After a grant, pointer = granted+1 mod NCH; otherwise the pointer holds.
REQ-011 A granted channel's result is registered on that edge, drives out_resp/out_data for exactly one cycle, and the channel returns to IDLE.
- Minimum latency: cmd sampled at E0, operand2 at E1, result visible after E2 and cleared after E3.
REQ-012 In the result cycle the channel is IDLE and SHALL accept a new cmd (back-to-back), whose result appears no earlier than 3 edges later.
REQ-013 Invalid command: bypasses arbitration, completes on the first edge in WAIT with resp 2 and data 0.
REQ-014 ADD: result = op1+op2 mod 2^DW; resp 2 with data 0 if carry-out, else resp 1.
REQ-015 SUB: result = op1-op2; resp 2 with data 0 if op2>op1, else resp 1.
REQ-016 LSH/RSH: logical shift of op1 by op2[$clog2(DW)-1:0]; upper op2 bits ignored; always resp 1.
REQ-017 Outside a channel's result cycle, its out_resp=0 and out_data=0.
REQ-018 ADD and LSH completions on different channels in the same cycle are both permitted.

Reset
REQ-019 While reset=0, asynchronously:
- all FSMs to IDLE;
- out_busy, out_resp and out_data to 0;
- both arbiter pointers to 0;
- captured operands and commands discarded.
REQ-020 A reset mid-operation drops the pending request with no response; the first edge with reset=1 samples req_cmd_in normally.

Structure
REQ-021 Package calc2_pkg holds: command/response enums, the channel-state typedef, and width helpers.
REQ-022 Sub-module calc2_rr_arb(N) holds the request vector, one-hot grant and wrapping pointer; it is instantiated once per unit.
REQ-023 Operand registers are per channel; datapaths for each unit are shared, with the operand mux selected by the grant.

Verification
REQ-024 Directed scenarios:
- ch0 ADD 5,7 alone -> after E2 ch0 resp 1 data 12 for one cycle; busy high for 2 cycles.
- DW=32, ch1 ADD 0xFFFFFFFF,1 -> resp 2 data 0; ch2 SUB 3,4 -> resp 2 data 0; SUB 4,3 -> resp 1 data 1.
- All 4 channels ADD simultaneously, pointer 0 -> completions ch0,ch1,ch2,ch3 on consecutive cycles; repeat -> order restarts at ch0 (pointer wraps).
- ch0 ADD and ch1 LSH 1,31 same cycle -> both complete the same cycle; ch1 data 0x80000000 resp 1; RSH 0x80000000,33 -> data 0x40000000.
- ch3 cmd 0xF -> resp 2 data 0 after E2; ch0 back-to-back ADD in result cycle -> second result 3 edges after the first.
- reset low while ch0-ch3 in WAIT -> all outputs 0 immediately, no responses afterwards; a new ADD after release -> normal latency.

Source files
------------

// File: rtl/calc2_pkg.sv
// Shared types and helpers for the two-operand calculator core.
// Holds the command/response codes, the per-channel state type and the index-width helper.
package calc2_pkg;

    typedef enum logic [3:0] {
        CmdNop = 4'd0,
        CmdAdd = 4'd1,
        CmdSub = 4'd2,
        CmdLsh = 4'd5,
        CmdRsh = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RespNone = 2'd0,
        RespOk   = 2'd1,
        RespErr  = 2'd2,
        RespRsvd = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOp2  = 2'd1,
        StWait = 2'd2
    } ch_state_e;

    // Width of an index into n items; at least one bit so n == 1 still yields a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_arith(input logic [3:0] cmd);
        return (cmd == CmdAdd) || (cmd == CmdSub);
    endfunction

    function automatic logic is_shift(input logic [3:0] cmd);
        return (cmd == CmdLsh) || (cmd == CmdRsh);
    endfunction

    function automatic logic is_valid(input logic [3:0] cmd);
        return is_arith(cmd) || is_shift(cmd);
    endfunction

endpackage

// File: rtl/calc2_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping modulo N.
// The pointer moves to one past the winner after every grant and holds otherwise.
module calc2_rr_arb
    import calc2_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               req,
    output logic [N-1:0]               gnt,
    output logic [idx_width(N)-1:0]    gnt_idx
);

    localparam int unsigned IW = idx_width(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr_q) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/calc2_core.sv
// Multi-channel two-operand calculator: each channel captures a command and two operands,
// then competes for a shared add/sub unit or a shared shift unit and returns a one-cycle result.
module calc2_core
    import calc2_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 32
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic [NCH*4-1:0]    req_cmd_in,
    input  logic [NCH*DW-1:0]   req_data_in,
    output logic [NCH-1:0]      out_busy,
    output logic [NCH*2-1:0]    out_resp,
    output logic [NCH*DW-1:0]   out_data
);

    localparam int unsigned IW = idx_width(NCH);
    localparam int unsigned SW = $clog2(DW);

    ch_state_e       state_q [NCH];
    logic [3:0]      cmd_q   [NCH];
    logic [DW-1:0]   op1_q   [NCH];
    logic [DW-1:0]   op2_q   [NCH];
    resp_e           resp_q  [NCH];
    logic [DW-1:0]   data_q  [NCH];
    logic [NCH-1:0]  busy_q;

    logic [NCH-1:0]  arith_req;
    logic [NCH-1:0]  arith_gnt;
    logic [IW-1:0]   arith_idx;
    logic [NCH-1:0]  shift_req;
    logic [NCH-1:0]  shift_gnt;
    logic [IW-1:0]   shift_idx;

    logic [DW-1:0]   a_op1;
    logic [DW-1:0]   a_op2;
    logic [DW:0]     add_full;
    resp_e           arith_resp;
    logic [DW-1:0]   arith_res;
    logic [DW-1:0]   s_op1;
    logic [SW-1:0]   s_amt;
    logic [DW-1:0]   shift_res;

    // Invalid commands never request a unit; they resolve directly in the WAIT state.
    always_comb begin
        arith_req = '0;
        shift_req = '0;
        for (int k = 0; k < NCH; k++) begin
            arith_req[k] = (state_q[k] == StWait) && is_arith(cmd_q[k]);
            shift_req[k] = (state_q[k] == StWait) && is_shift(cmd_q[k]);
        end
    end

    calc2_rr_arb #(
        .N (NCH)
    ) u_arith_arb (
        .clk     (c_clk),
        .rst_n   (reset),
        .req     (arith_req),
        .gnt     (arith_gnt),
        .gnt_idx (arith_idx)
    );

    calc2_rr_arb #(
        .N (NCH)
    ) u_shift_arb (
        .clk     (c_clk),
        .rst_n   (reset),
        .req     (shift_req),
        .gnt     (shift_gnt),
        .gnt_idx (shift_idx)
    );

    always_comb begin
        a_op1      = op1_q[arith_idx];
        a_op2      = op2_q[arith_idx];
        add_full   = {1'b0, a_op1} + {1'b0, a_op2};
        arith_resp = RespOk;
        arith_res  = '0;
        if (cmd_q[arith_idx] == CmdSub) begin
            if (a_op2 > a_op1) begin
                arith_resp = RespErr;
            end else begin
                arith_res = a_op1 - a_op2;
            end
        end else if (add_full[DW]) begin
            arith_resp = RespErr;
        end else begin
            arith_res = add_full[DW-1:0];
        end
    end

    always_comb begin
        s_op1     = op1_q[shift_idx];
        s_amt     = op2_q[shift_idx][SW-1:0];
        shift_res = (cmd_q[shift_idx] == CmdRsh) ? (s_op1 >> s_amt) : (s_op1 << s_amt);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= StIdle;
                cmd_q[k]   <= 4'd0;
                op1_q[k]   <= '0;
                op2_q[k]   <= '0;
                resp_q[k]  <= RespNone;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                resp_q[k] <= RespNone;
                data_q[k] <= '0;
                case (state_q[k])
                    StIdle: begin
                        if (req_cmd_in[4*k +: 4] != 4'd0) begin
                            cmd_q[k]   <= req_cmd_in[4*k +: 4];
                            op1_q[k]   <= req_data_in[DW*k +: DW];
                            state_q[k] <= StOp2;
                            busy_q[k]  <= 1'b1;
                        end
                    end
                    StOp2: begin
                        op2_q[k]   <= req_data_in[DW*k +: DW];
                        state_q[k] <= StWait;
                    end
                    StWait: begin
                        if (!is_valid(cmd_q[k])) begin
                            resp_q[k]  <= RespErr;
                            state_q[k] <= StIdle;
                            busy_q[k]  <= 1'b0;
                        end else if (arith_gnt[k]) begin
                            resp_q[k]  <= arith_resp;
                            data_q[k]  <= arith_res;
                            state_q[k] <= StIdle;
                            busy_q[k]  <= 1'b0;
                        end else if (shift_gnt[k]) begin
                            resp_q[k]  <= RespOk;
                            data_q[k]  <= shift_res;
                            state_q[k] <= StIdle;
                            busy_q[k]  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[k] <= StIdle;
                        busy_q[k]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        out_busy = busy_q;
        out_resp = '0;
        out_data = '0;
        for (int k = 0; k < NCH; k++) begin
            out_resp[2*k +: 2]   = resp_q[k];
            out_data[DW*k +: DW] = data_q[k];
        end
    end

endmodule

// File: tb/tb_calc2_core.sv
// Self-checking bench for calc2_core: per-channel scoreboard of expected responses plus
// directed latency, arbitration-order and reset checks.
module tb_calc2_core;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic                c_clk = 1'b0;
    logic                reset;
    logic [NCH*4-1:0]    req_cmd_in;
    logic [NCH*DW-1:0]   req_data_in;
    logic [NCH-1:0]      out_busy;
    logic [NCH*2-1:0]    out_resp;
    logic [NCH*DW-1:0]   out_data;

    logic [3:0]      cmd_v   [NCH];
    logic [DW-1:0]   dat_v   [NCH];
    logic [DW-1:0]   pend_op2[NCH];
    logic [33:0]     exp_q   [NCH][$];
    logic [33:0]     exp_e;
    int              done_cyc[NCH];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_errors = 0;
    int              c0;
    int              c1;

    calc2_core #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_busy    (out_busy),
        .out_resp    (out_resp),
        .out_data    (out_data)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    always_comb begin
        req_cmd_in  = '0;
        req_data_in = '0;
        for (int k = 0; k < NCH; k++) begin
            req_cmd_in[4*k +: 4]    = cmd_v[k];
            req_data_in[DW*k +: DW] = dat_v[k];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] s;
        case (cmd)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            end
            4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Scoreboard monitor: every nonzero response must match the oldest expectation.
    always @(negedge c_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (out_resp[2*k +: 2] != 2'd0) begin
                done_cyc[k] = cyc;
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_resp_ch%0d", k), 64'(out_resp[2*k +: 2]), 64'd0);
                end else begin
                    exp_e = exp_q[k].pop_front();
                    check($sformatf("resp_ch%0d", k), 64'(out_resp[2*k +: 2]), 64'(exp_e[33:32]));
                    check($sformatf("data_ch%0d", k), 64'(out_data[DW*k +: DW]), 64'(exp_e[31:0]));
                end
            end else begin
                check($sformatf("idle_data_ch%0d", k), 64'(out_data[DW*k +: DW]), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic req(input int k, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b);
        cmd_v[k]    = cmd;
        dat_v[k]    = a;
        pend_op2[k] = b;
        exp_q[k].push_back(model(cmd, a, b));
    endtask

    task automatic phase2();
        for (int k = 0; k < NCH; k++) begin
            if (cmd_v[k] != 4'd0) begin
                dat_v[k] = pend_op2[k];
                cmd_v[k] = 4'd0;
            end
        end
    endtask

    function automatic logic all_empty();
        for (int k = 0; k < NCH; k++) begin
            if (exp_q[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && !all_empty(); i++) tick();
        check(tag, 64'(all_empty()), 64'd1);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NCH; k++) begin
            cmd_v[k]    = 4'd0;
            dat_v[k]    = '0;
            pend_op2[k] = '0;
            done_cyc[k] = -1;
        end
        reset = 1'b0;
        #1;
        check("reset_busy", 64'(out_busy), 64'd0);
        check("reset_resp", 64'(out_resp), 64'd0);
        check("reset_data", out_data[63:0], 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single ADD: busy for two cycles, result after E2
        c0 = cyc;
        req(0, 4'd1, 32'd5, 32'd7);
        tick();
        check("add_busy_e0", 64'(out_busy[0]), 64'd1);
        phase2();
        tick();
        check("add_busy_e1", 64'(out_busy[0]), 64'd1);
        tick();
        check("add_busy_e2", 64'(out_busy[0]), 64'd0);
        check("add_resp_e2", 64'(out_resp[1:0]), 64'd1);
        drain("drain_add");
        check("add_latency", 64'(done_cyc[0]), 64'(c0 + 3));

        // Overflow and underflow contend for the arithmetic unit
        req(1, 4'd1, 32'hFFFF_FFFF, 32'd1);
        req(2, 4'd2, 32'd3, 32'd4);
        tick();
        phase2();
        tick();
        drain("drain_ovf");
        req(2, 4'd2, 32'd4, 32'd3);
        tick();
        phase2();
        tick();
        drain("drain_sub");

        // All channels ADD at once from pointer 0, twice to exercise wrap
        do_reset();
        for (int r = 0; r < 2; r++) begin
            c0 = cyc;
            for (int k = 0; k < NCH; k++) req(k, 4'd1, 32'(k * 10), 32'(r + 1));
            tick();
            phase2();
            tick();
            drain("drain_rr");
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("rr_order_r%0d_ch%0d", r, k), 64'(done_cyc[k]), 64'(c0 + 3 + k));
            end
        end

        // ADD and LSH complete in the same cycle on separate units
        req(0, 4'd1, 32'd1, 32'd2);
        req(1, 4'd5, 32'd1, 32'd31);
        tick();
        phase2();
        tick();
        drain("drain_dual");
        check("dual_same_cycle", 64'(done_cyc[1]), 64'(done_cyc[0]));
        req(1, 4'd6, 32'h8000_0000, 32'd33);
        tick();
        phase2();
        tick();
        drain("drain_rsh");

        // Invalid command, then back-to-back ADD issued in the result cycle
        c0 = cyc;
        req(3, 4'hF, 32'd9, 32'd9);
        tick();
        phase2();
        tick();
        drain("drain_inv");
        check("inv_latency", 64'(done_cyc[3]), 64'(c0 + 3));
        c0 = cyc;
        req(0, 4'd1, 32'd100, 32'd1);
        tick();
        phase2();
        tick();
        tick();
        req(0, 4'd1, 32'd200, 32'd2);
        tick();
        phase2();
        tick();
        tick();
        c1 = done_cyc[0];
        drain("drain_b2b");
        check("b2b_first", 64'(c1), 64'(c0 + 3));
        check("b2b_second", 64'(done_cyc[0]), 64'(c0 + 6));

        // Mixed random traffic on all channels
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NCH; k++) begin
                logic [3:0] cmds [5];
                cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3};
                req(k, cmds[$urandom_range(0, 4)], $urandom(), $urandom_range(0, 40));
            end
            tick();
            phase2();
            tick();
            drain("drain_rand");
        end

        // Reset while every channel waits: no responses may follow
        for (int k = 0; k < NCH; k++) req(k, 4'd1, 32'd1, 32'd1);
        tick();
        phase2();
        tick();
        check("pre_reset_busy", 64'(out_busy), 64'hF);
        reset = 1'b0;
        #1;
        check("async_busy", 64'(out_busy), 64'd0);
        check("async_resp", 64'(out_resp), 64'd0);
        check("async_data", out_data[63:0], 64'd0);
        for (int k = 0; k < NCH; k++) exp_q[k].delete();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        c0 = cyc;
        req(2, 4'd1, 32'd40, 32'd2);
        tick();
        phase2();
        tick();
        drain("drain_post_reset");
        check("post_reset_latency", 64'(done_cyc[2]), 64'(c0 + 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
